spi_cmd_decoder: RTL and testbench
==================================

// Module: spi_cmd_decoder
// PURPOSE
//  Sits downstream of the SPI slave read port and upstream of its write port, on a single clock.
//  Parses CSN-delimited frames of the form opcode, address bytes, data bytes into register-bus
//  write/read accesses. Read data is returned to the slave TX path, one word per access.
// PARAMETERS
//  DW          8       word width; equals SSIZE*CSNUM of the slave
//  ADDR_BYTES  2       address words following the opcode, MSB first
//  AW          DW*ADDR_BYTES  register address width (derived, do not override)
// PORTS
//  clock         in   1    sole clock
//  rst           in   1    synchronous, active-high reset
//  stream_sof    in   1    1-cycle pulse, CSN fell
//  stream_eof    in   1    1-cycle pulse, CSN rose
//  rd_vld        in   1    slave RX word available
//  rd_data       in   DW   slave RX word
//  rd_en         out  1    consume RX word; a word is taken when rd_vld && rd_en
//  tx_en         out  1    TX word valid, to slave wr_en
//  tx_data       out  DW   TX word, to slave wr_data
//  tx_ready      in   1    slave accepts; a word is taken when tx_en && tx_ready
//  reg_wr_en     out  1    register write strobe, 1 cycle
//  reg_rd_en     out  1    register read request, 1 cycle
//  reg_addr      out  AW   access address
//  reg_wdata     out  DW   write data
//  reg_rd_vld    in   1    read data valid (any latency >= 1)
//  reg_rdata     in   DW   read data
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0: rd_en, tx_en, tx_data, reg_*, addr counter, byte counter.
//    Reset mid-frame aborts the frame and drops any pending TX word.
//  - States: IDLE, OPCODE, ADDR, WDATA, RDREQ, RDWAIT, RDPUSH, DISCARD.
//  - IDLE: rd_en=1. Stray words are consumed and dropped. stream_sof -> OPCODE.
//  - OPCODE: 0x02 (WRITE) or 0x03 (READ) -> ADDR with byte count cleared. Any other opcode -> DISCARD.
//  - ADDR: shift addr <= {addr, rd_data} for ADDR_BYTES words.
//    After the last word: WRITE -> WDATA, READ -> RDREQ.
//  - WDATA: each consumed word drives reg_wr_en=1 on the next cycle,
//    with reg_wdata=word and reg_addr=current addr. addr increments after each write.
//  - RDREQ: reg_rd_en=1 for exactly one cycle -> RDWAIT.
//    RDWAIT: on reg_rd_vld, latch tx_data=reg_rdata -> RDPUSH.
//    RDPUSH: hold tx_en until tx_ready. Then addr+1 -> RDREQ.
//  - READ mode: rd_en stays 1 from RDREQ through RDPUSH. MOSI dummy words are consumed and dropped.
//  - DISCARD: rd_en=1, all words dropped, until eof.
//  - rd_en is 1 in every state except during reset.
//  - addr wraps modulo 2^AW with no flag.
//  - stream_eof in any state -> IDLE next cycle.
//    A pending tx_en word is withdrawn. An outstanding reg read is allowed to complete, but its
//    reg_rd_vld is ignored. A word consumed in the same cycle as eof is still processed.
//  - stream_sof outside IDLE restarts at OPCODE; the partial frame is abandoned.
//    sof and rd_vld in the same cycle: sof takes effect first, and that word is the opcode.
//  - eof before the address is complete: no register access is issued.
// CONFIGURATION
//  SPI_CMD_STATUS_EN defined:
//    - Opcode 0x05 (STATUS) returns one word {DW-2 zeros, tx_abort, bad_op} via RDPUSH, then DISCARD.
//    - bad_op: sticky, set on an unknown opcode.
//    - tx_abort: sticky, set when eof withdraws tx_en.
//    - Both flags clear when the status word is accepted (tx_ready) and on rst.
//  SPI_CMD_STATUS_EN undefined: 0x05 is an unknown opcode -> DISCARD. No flag registers exist.
// STRUCTURE
//  - Package spi_cmd_pkg: OP_WRITE/OP_READ/OP_STATUS localparams, state encoding localparams.
//  - Single module, no sub-module. The STATUS logic is inline under the macro.
// TESTING
//  - sof, words 02 12 34 AA BB, eof -> reg_wr_en twice: (0x1234,AA) then (0x1235,BB); no tx_en.
//  - sof, 03 00 10, dummies; reg_rdata 5A then 5B (3-cycle latency)
//      -> tx_data 5A then 5B; reg_rd_en addr 0x0010 then 0x0011.
//  - sof, 02 FF FF 01 02, eof -> writes at 0xFFFF, then 0x0000 (wrap).
//  - sof, 7E 01 02, eof -> no reg strobes, all words consumed. Then a valid WRITE frame succeeds.
//  - READ with tx_ready=0, eof during RDPUSH -> tx_en drops next cycle, state IDLE.
//    Then sof mid WDATA restarts parsing at OPCODE.
//  - [SPI_CMD_STATUS_EN] bad opcode frame, then sof 05 -> tx_data 0x01. A second 05 -> 0x00.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Opcodes and FSM state encoding shared by the SPI command decoder.
package spi_cmd_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h05;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StOpcode  = 3'd1;
  localparam logic [2:0] StAddr    = 3'd2;
  localparam logic [2:0] StWdata   = 3'd3;
  localparam logic [2:0] StRdReq   = 3'd4;
  localparam logic [2:0] StRdWait  = 3'd5;
  localparam logic [2:0] StRdPush  = 3'd6;
  localparam logic [2:0] StDiscard = 3'd7;

endpackage

// File: rtl/spi_cmd_decoder.sv
// Turns CSN-delimited SPI frames (opcode, address, data) into register-bus accesses.
// Optional STATUS opcode and sticky error flags are enabled by defining SPI_CMD_STATUS_EN.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned ADDR_BYTES = 2,
  parameter int unsigned AW         = DW * ADDR_BYTES
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          stream_sof,
  input  logic          stream_eof,
  input  logic          rd_vld,
  input  logic [DW-1:0] rd_data,
  output logic          rd_en,
  output logic          tx_en,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ready,
  output logic          reg_wr_en,
  output logic          reg_rd_en,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  input  logic          reg_rd_vld,
  input  logic [DW-1:0] reg_rdata
);

  localparam int unsigned   BW       = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [BW-1:0] LastByte = BW'(ADDR_BYTES - 1);

  logic [2:0]    state_q, state_d, op_state;
  logic [AW-1:0] addr_q, addr_d, reg_addr_q, reg_addr_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0] tx_data_q, tx_data_d, reg_wdata_q, reg_wdata_d;
  logic          is_read_q, is_read_d, rd_en_q, tx_en_q, tx_en_d;
  logic          reg_wr_en_q, reg_wr_en_d, reg_rd_en_q, reg_rd_en_d;
  // rd_out: a register read is in flight; drop: its response belongs to an abandoned frame
  logic          rd_out_q, rd_out_d, drop_q, drop_d;
  logic          take, tx_acc, op_take, op_write, op_read;

  assign take     = rd_vld & rd_en_q;
  assign tx_acc   = tx_en_q & tx_ready;
  assign op_write = (rd_data == DW'(OP_WRITE));
  assign op_read  = (rd_data == DW'(OP_READ));

`ifdef SPI_CMD_STATUS_EN
  logic bad_op_q, bad_op_d, tx_abort_q, tx_abort_d, is_status_q, is_status_d, op_status;
  assign op_status = (rd_data == DW'(OP_STATUS));
`endif

  always_comb begin
    if (op_write || op_read) op_state = StAddr;
`ifdef SPI_CMD_STATUS_EN
    else if (op_status) op_state = StRdPush;
`endif
    else op_state = StDiscard;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    bcnt_d      = bcnt_q;
    is_read_d   = is_read_q;
    tx_en_d     = tx_en_q;
    tx_data_d   = tx_data_q;
    reg_wr_en_d = 1'b0;
    reg_rd_en_d = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    rd_out_d    = rd_out_q & ~reg_rd_vld;
    drop_d      = drop_q & ~reg_rd_vld;
    op_take     = 1'b0;
`ifdef SPI_CMD_STATUS_EN
    bad_op_d    = bad_op_q;
    tx_abort_d  = tx_abort_q;
    is_status_d = is_status_q;
`endif

    case (state_q)
      StOpcode: op_take = take;
      StAddr: begin
        if (take) begin
          addr_d = (addr_q << DW) | AW'(rd_data);
          if (bcnt_q == LastByte) state_d = is_read_q ? StRdReq : StWdata;
          else bcnt_d = bcnt_q + 1'b1;
        end
      end
      StWdata: begin
        if (take) begin
          reg_wr_en_d = 1'b1;
          reg_wdata_d = rd_data;
          reg_addr_d  = addr_q;
          addr_d      = addr_q + 1'b1;
        end
      end
      StRdReq: begin
        // Hold off while a stale response from an abandoned frame is still due
        if (!drop_q) begin
          reg_rd_en_d = 1'b1;
          reg_addr_d  = addr_q;
          rd_out_d    = 1'b1;
          state_d     = StRdWait;
        end
      end
      StRdWait: begin
        if (reg_rd_vld && !drop_q) begin
          tx_data_d = reg_rdata;
          tx_en_d   = 1'b1;
          state_d   = StRdPush;
        end
      end
      StRdPush: begin
        if (tx_acc) begin
          tx_en_d = 1'b0;
`ifdef SPI_CMD_STATUS_EN
          if (is_status_q) begin
            state_d    = StDiscard;
            bad_op_d   = 1'b0;
            tx_abort_d = 1'b0;
          end else
`endif
          begin
            addr_d  = addr_q + 1'b1;
            state_d = StRdReq;
          end
        end
      end
      default: ;
    endcase

    if (stream_eof || stream_sof) begin
`ifdef SPI_CMD_STATUS_EN
      if (stream_eof && tx_en_q && !tx_ready) tx_abort_d = 1'b1;
`endif
      tx_en_d = 1'b0;
      if (reg_rd_en_d) begin
        reg_rd_en_d = 1'b0;
        rd_out_d    = 1'b0;
      end
      drop_d  = rd_out_d;
      state_d = stream_sof ? StOpcode : StIdle;
      op_take = stream_sof & take;
      if (stream_sof) reg_wr_en_d = 1'b0;
    end

    if (op_take) begin
      state_d   = op_state;
      bcnt_d    = '0;
      is_read_d = op_read;
`ifdef SPI_CMD_STATUS_EN
      is_status_d = op_status;
      if (op_status) begin
        tx_en_d   = 1'b1;
        tx_data_d = DW'({tx_abort_q, bad_op_q});
      end else if (!op_write && !op_read) begin
        bad_op_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      bcnt_q      <= '0;
      is_read_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      rd_out_q    <= 1'b0;
      drop_q      <= 1'b0;
`ifdef SPI_CMD_STATUS_EN
      bad_op_q    <= 1'b0;
      tx_abort_q  <= 1'b0;
      is_status_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
      is_read_q   <= is_read_d;
      rd_en_q     <= 1'b1;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_rd_en_q <= reg_rd_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      rd_out_q    <= rd_out_d;
      drop_q      <= drop_d;
`ifdef SPI_CMD_STATUS_EN
      bad_op_q    <= bad_op_d;
      tx_abort_q  <= tx_abort_d;
      is_status_q <= is_status_d;
`endif
    end
  end

  assign rd_en     = rd_en_q;
  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign reg_wr_en = reg_wr_en_q;
  assign reg_rd_en = reg_rd_en_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed frames plus randomized write/read/bad frames
// checked against a frame-level model; STATUS checks only when SPI_CMD_STATUS_EN is defined.
module tb_spi_cmd_decoder;

  typedef logic [7:0] bq_t[$];

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        stream_sof = 1'b0, stream_eof = 1'b0, rd_vld = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        rd_en, tx_en, reg_wr_en, reg_rd_en;
  logic [7:0]  tx_data, reg_wdata;
  logic        tx_ready = 1'b1;
  logic [15:0] reg_addr;
  logic        reg_rd_vld = 1'b0;
  logic [7:0]  reg_rdata = 8'h00;

  int vectors = 0, miscompares = 0;
  int tx_mode = 0;  // 0: always ready, 1: random, 2: never ready
  bit exp_bad = 1'b0, exp_abort = 1'b0;

  logic [23:0] wr_log[$];
  logic [15:0] rd_log[$];
  logic [7:0]  tx_log[$];

  logic        pend = 1'b0;
  int          cnt = 0;
  logic [15:0] paddr = 16'h0;

  spi_cmd_decoder #(.DW(8), .ADDR_BYTES(2)) dut (
    .clock(clock), .rst(rst), .stream_sof(stream_sof), .stream_eof(stream_eof),
    .rd_vld(rd_vld), .rd_data(rd_data), .rd_en(rd_en), .tx_en(tx_en), .tx_data(tx_data),
    .tx_ready(tx_ready), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rd_vld(reg_rd_vld), .reg_rdata(reg_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rdf(input logic [15:0] a);
    return a[7:0] + a[15:8] + 8'h4A;
  endfunction

  // Register slave: fixed 3-cycle read latency, data is a function of the address
  always @(negedge clock) begin
    reg_rd_vld <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
    end else if (reg_rd_en) begin
      pend  <= 1'b1;
      cnt   <= 3;
      paddr <= reg_addr;
    end else if (pend) begin
      if (cnt == 1) begin
        reg_rd_vld <= 1'b1;
        reg_rdata  <= rdf(paddr);
        pend       <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (!rst) begin
      if (reg_wr_en) wr_log.push_back({reg_addr, reg_wdata});
      if (reg_rd_en) rd_log.push_back(reg_addr);
      if (tx_en && tx_ready) tx_log.push_back(tx_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    stream_sof = 1'b0;
    stream_eof = 1'b0;
    rd_vld     = 1'b0;
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  endtask

  task automatic send_word(input logic [7:0] w, input bit sof, input bit eof);
    if ($urandom_range(0, 2) == 0) cyc();
    cyc();
    rd_vld     = 1'b1;
    rd_data    = w;
    stream_sof = sof;
    stream_eof = eof;
    chk("rd_en", rd_en, 1);
  endtask

  task automatic begin_frame(input logic [7:0] op);
    wr_log.delete();
    rd_log.delete();
    tx_log.delete();
    if ($urandom_range(0, 1) == 1) begin
      send_word(op, 1'b1, 1'b0);
    end else begin
      cyc();
      stream_sof = 1'b1;
      send_word(op, 1'b0, 1'b0);
    end
  endtask

  task automatic end_frame();
    cyc();
    stream_eof = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic write_frame(input logic [15:0] a, input bq_t d);
    bit eof_last;
    eof_last = 1'($urandom_range(0, 1));
    begin_frame(8'h02);
    send_word(a[15:8], 1'b0, 1'b0);
    send_word(a[7:0], 1'b0, 1'b0);
    for (int i = 0; i < d.size(); i++) send_word(d[i], 1'b0, eof_last && (i == d.size() - 1));
    if (eof_last) repeat (4) cyc();
    else end_frame();
    chk("wr_count", wr_log.size(), d.size());
    for (int i = 0; i < d.size(); i++)
      if (i < wr_log.size()) chk("wr_addr_data", wr_log[i], {a + 16'(i), d[i]});
    chk("wr_no_tx", tx_log.size(), 0);
    chk("wr_no_rd", rd_log.size(), 0);
  endtask

  // After the n-th word is accepted the decoder has already issued read n+1 before eof lands
  task automatic read_frame(input logic [15:0] a, input int n);
    begin_frame(8'h03);
    send_word(a[15:8], 1'b0, 1'b0);
    send_word(a[7:0], 1'b0, 1'b0);
    for (int k = 0; k < 400 && tx_log.size() < n; k++) begin
      cyc();
      if ($urandom_range(0, 3) == 0) begin
        rd_vld  = 1'b1;
        rd_data = 8'($urandom);
      end
    end
    end_frame();
    chk("rd_tx_count", tx_log.size(), n);
    for (int i = 0; i < n; i++)
      if (i < tx_log.size()) chk("rd_tx_data", tx_log[i], rdf(a + 16'(i)));
    chk("rd_req_count", rd_log.size(), n + 1);
    for (int i = 0; i <= n; i++)
      if (i < rd_log.size()) chk("rd_req_addr", rd_log[i], a + 16'(i));
    chk("rd_no_wr", wr_log.size(), 0);
  endtask

  task automatic bad_frame();
    begin_frame(8'h7E);
    send_word(8'h01, 1'b0, 1'b0);
    send_word(8'h02, 1'b0, 1'b0);
    end_frame();
    chk("bad_no_wr", wr_log.size(), 0);
    chk("bad_no_rd", rd_log.size(), 0);
    chk("bad_no_tx", tx_log.size(), 0);
    exp_bad = 1'b1;
  endtask

`ifdef SPI_CMD_STATUS_EN
  task automatic status_frame();
    logic [7:0] exp;
    exp = {6'b0, exp_abort, exp_bad};
    begin_frame(8'h05);
    for (int k = 0; k < 50 && tx_log.size() < 1; k++) cyc();
    end_frame();
    chk("status_count", tx_log.size(), 1);
    if (tx_log.size() > 0) chk("status_word", tx_log[0], exp);
    exp_bad   = 1'b0;
    exp_abort = 1'b0;
  endtask
`endif

  initial begin
    bq_t d;
    logic [15:0] a;
    int kind;

    repeat (3) cyc();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_reg_wr_en", reg_wr_en, 0);
    chk("rst_reg_rd_en", reg_rd_en, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    rst = 1'b0;
    repeat (2) cyc();
    chk("idle_rd_en", rd_en, 1);

`ifdef SPI_CMD_STATUS_EN
    status_frame();
    bad_frame();
    status_frame();
    status_frame();
`endif

    d = '{8'hAA, 8'hBB};
    write_frame(16'h1234, d);
    read_frame(16'h0010, 2);
    d = '{8'h01, 8'h02};
    write_frame(16'hFFFF, d);
    bad_frame();
    d = '{8'h3C};
    write_frame(16'h0456, d);

    for (int f = 0; f < 20; f++) begin
      kind = $urandom_range(0, 5);
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      if (kind <= 2) begin
        d.delete();
        for (int i = 0; i < $urandom_range(1, 4); i++) d.push_back(8'($urandom));
        write_frame(a, d);
      end else if (kind <= 4) begin
        tx_mode = $urandom_range(0, 1);
        read_frame(a, $urandom_range(1, 4));
        tx_mode = 0;
      end else begin
        bad_frame();
      end
    end

    // eof while a read word is stalled on tx_ready
    tx_mode = 2;
    begin_frame(8'h03);
    send_word(8'h00, 1'b0, 1'b0);
    send_word(8'h40, 1'b0, 1'b0);
    for (int k = 0; k < 100 && !tx_en; k++) cyc();
    chk("push_tx_en", tx_en, 1);
    cyc();
    stream_eof = 1'b1;
    cyc();
    chk("abort_tx_en", tx_en, 0);
    tx_mode = 0;
    repeat (4) cyc();
    chk("abort_no_tx", tx_log.size(), 0);
    exp_abort = 1'b1;

    // sof mid-WDATA: the same-cycle word becomes the new opcode
    begin_frame(8'h02);
    send_word(8'h12, 1'b0, 1'b0);
    send_word(8'h34, 1'b0, 1'b0);
    send_word(8'hAA, 1'b0, 1'b0);
    send_word(8'h02, 1'b1, 1'b0);
    send_word(8'h00, 1'b0, 1'b0);
    send_word(8'h20, 1'b0, 1'b0);
    send_word(8'h77, 1'b0, 1'b0);
    end_frame();
    chk("restart_wr_count", wr_log.size(), 2);
    if (wr_log.size() > 1) begin
      chk("restart_wr0", wr_log[0], 24'h1234AA);
      chk("restart_wr1", wr_log[1], 24'h002077);
    end

`ifdef SPI_CMD_STATUS_EN
    status_frame();
`endif

    // Reset mid-frame drops the pending TX word
    tx_mode = 2;
    begin_frame(8'h03);
    send_word(8'h00, 1'b0, 1'b0);
    send_word(8'h50, 1'b0, 1'b0);
    for (int k = 0; k < 100 && !tx_en; k++) cyc();
    chk("pre_rst_tx_en", tx_en, 1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_tx_en", tx_en, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    rst = 1'b0;
    tx_mode = 0;
    exp_bad = 1'b0;
    exp_abort = 1'b0;
    repeat (3) cyc();
    d = '{8'h99, 8'h66};
    write_frame(16'h0ABC, d);
`ifdef SPI_CMD_STATUS_EN
    status_frame();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
